// File: rtl/handshake_skid_slice.sv
// Two-entry valid/ready skid buffer. Every output comes straight from a flop,
// so there is no combinational path between the two handshake sides.
module handshake_skid_slice #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // State bits are {main_v, skid_v}; 2'b01 cannot be reached.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_d_nxt;
  logic [DATA_W-1:0] skid_d;
  logic [DATA_W-1:0] skid_d_nxt;
  logic              accept_c;
  logic              emit_c;

  assign accept_c = valid_i & ~state_q[0];
  assign emit_c   = ready_i & state_q[1];

  // Next-state and datapath steering; data_i is only captured on an accept.
  always_comb begin
    state_d    = state_q;
    main_d_nxt = main_d;
    skid_d_nxt = skid_d;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          main_d_nxt = data_i;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept_c && emit_c) begin
          main_d_nxt = data_i;
        end else if (accept_c) begin
          skid_d_nxt = data_i;
          state_d    = ST_FULL;
        end else if (emit_c) begin
          state_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit_c) begin
          main_d_nxt = skid_d;
          state_d    = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_d  <= '0;
      skid_d  <= '0;
    end else begin
      state_q <= state_d;
      main_d  <= main_d_nxt;
      skid_d  <= skid_d_nxt;
    end
  end

  assign valid_o = state_q[1];
  assign ready_o = ~state_q[0];
  assign data_o  = main_d;

endmodule

// File: tb/tb_handshake_skid_slice.sv
// Scoreboard bench for handshake_skid_slice: a queue holds the beats inside the
// slice, emitted beats are popped and compared against data_o.
module tb_handshake_skid_slice;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic [W-1:0] data_i;
  logic         ready_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_data;
  logic         sb_emit;
  logic [W-1:0] sb_got;
  logic [W-1:0] sb_want;
  int           n_emit;

  handshake_skid_slice #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_i(ready_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected {valid_o, ready_o, data_o} from the queue model.
  function automatic logic [W+1:0] exp_bus();
    logic [W-1:0] d;
    d = (q.size() != 0) ? q[0] : last_data;
    return {q.size() != 0, q.size() < 2, d};
  endfunction

  // Drive one cycle from a negedge, update the model, land on the next negedge.
  task automatic step(input logic rst, input logic vi, input logic [W-1:0] di, input logic ri);
    logic acc;
    rst_n   = rst;
    valid_i = vi;
    data_i  = di;
    ready_i = ri;
    #1;
    sb_emit = 1'b0;
    if (!rst) begin
      q.delete();
      last_data = '0;
    end else begin
      acc = vi && (q.size() < 2);
      if (q.size() != 0 && ri) begin
        sb_emit   = 1'b1;
        sb_got    = data_o;
        sb_want   = q.pop_front();
        last_data = sb_want;
        n_emit++;
      end
      if (acc) q.push_back(di);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, W'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, W'($urandom), (i >= 3) ? 1'(i) : 1'b0);
      total++;
      if ({valid_o, ready_o, data_o} !== {1'b1 == 1'b0, 1'b1, W'(0)}) begin
        bad++;
        $display("FAIL reset_idle: got v=%b r=%b d=%h want v=0 r=1 d=00", valid_o, ready_o, data_o);
      end
    end
  endtask

  task automatic test_fill();
    step(1'b1, 1'b1, 8'h01, 1'b0);
    total++;
    if ({valid_o, ready_o, data_o} !== {2'b11, 8'h01}) begin
      bad++;
      $display("FAIL fill_edge1: got v=%b r=%b d=%h want v=1 r=1 d=01", valid_o, ready_o, data_o);
    end
    step(1'b1, 1'b1, 8'h02, 1'b0);
    total++;
    if ({valid_o, ready_o, data_o} !== {2'b10, 8'h01}) begin
      bad++;
      $display("FAIL fill_edge2: got v=%b r=%b d=%h want v=1 r=0 d=01", valid_o, ready_o, data_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'(i), W'($urandom), 1'b0);
      total++;
      if ({valid_o, ready_o, data_o} !== exp_bus()) begin
        bad++;
        $display("FAIL fill_hold: got %h want %h", {valid_o, ready_o, data_o}, exp_bus());
      end
    end
  endtask

  task automatic test_drain();
    step(1'b1, 1'b0, W'($urandom), 1'b1);
    total++;
    if (sb_got !== sb_want || !sb_emit) begin
      bad++;
      $display("FAIL drain_beat1: got %h want %h", sb_got, sb_want);
    end
    total++;
    if ({valid_o, ready_o, data_o} !== {2'b11, 8'h02}) begin
      bad++;
      $display("FAIL drain_edge1: got v=%b r=%b d=%h want v=1 r=1 d=02", valid_o, ready_o, data_o);
    end
    step(1'b1, 1'b0, W'($urandom), 1'b1);
    total++;
    if (sb_got !== sb_want || !sb_emit) begin
      bad++;
      $display("FAIL drain_beat2: got %h want %h", sb_got, sb_want);
    end
    total++;
    if ({valid_o, ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL drain_edge2: got v=%b r=%b want v=0 r=1", valid_o, ready_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, W'(i % 2), 1'b1);
      if (sb_emit) begin
        total++;
        if (sb_got !== sb_want) begin
          bad++;
          $display("FAIL stream_beat%0d: got %h want %h", i, sb_got, sb_want);
        end
      end
      total++;
      if ({valid_o, ready_o, data_o} !== {2'b11, W'(i % 2)}) begin
        bad++;
        $display("FAIL stream_out%0d: got v=%b r=%b d=%h want v=1 r=1 d=%h",
                 i, valid_o, ready_o, data_o, W'(i % 2));
      end
    end
    step(1'b1, 1'b0, '0, 1'b1);
    total++;
    if (sb_got !== sb_want || !sb_emit || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_last: got d=%h v=%b want d=%h v=0", sb_got, valid_o, sb_want);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vi_d[7];
    logic         vi_v[7];
    logic         ri_v[7];
    int           base;
    vi_d = '{8'hA5, 8'hB6, 8'hC7, 8'hC7, 8'hC7, 8'h00, 8'h00};
    vi_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ri_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    base = n_emit;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vi_v[i], vi_d[i], ri_v[i]);
      if (sb_emit) begin
        total++;
        if (sb_got !== sb_want) begin
          bad++;
          $display("FAIL bp_order%0d: got %h want %h", i, sb_got, sb_want);
        end
      end
      total++;
      if ({valid_o, ready_o, data_o} !== exp_bus()) begin
        bad++;
        $display("FAIL bp_out%0d: got %h want %h", i, {valid_o, ready_o, data_o}, exp_bus());
      end
      if (i == 1 || i == 2) begin
        total++;
        if ({ready_o, data_o} !== {1'b0, 8'hA5}) begin
          bad++;
          $display("FAIL bp_stall%0d: got r=%b d=%h want r=0 d=a5", i, ready_o, data_o);
        end
      end
    end
    total++;
    if (n_emit - base != 3 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got %0d want 3", n_emit - base);
    end
  endtask

  task automatic test_reset_full();
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b1, 1'b1, 8'h4D, 1'b0);
    total++;
    if ({valid_o, ready_o} !== 2'b10) begin
      bad++;
      $display("FAIL rf_full: got v=%b r=%b want v=1 r=0", valid_o, ready_o);
    end
    step(1'b0, 1'b1, 8'h5E, 1'b1);
    total++;
    if ({valid_o, ready_o, data_o} !== {2'b01, 8'h00}) begin
      bad++;
      $display("FAIL rf_reset: got v=%b r=%b d=%h want v=0 r=1 d=00", valid_o, ready_o, data_o);
    end
    step(1'b1, 1'b0, 8'h6F, 1'b1);
    total++;
    if ({valid_o, ready_o, data_o} !== {2'b01, 8'h00}) begin
      bad++;
      $display("FAIL rf_discard: got v=%b r=%b d=%h want v=0 r=1 d=00", valid_o, ready_o, data_o);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    ready_i   = 1'b0;
    last_data = '0;
    n_emit    = 0;
    sb_emit   = 1'b0;
    sb_got    = '0;
    sb_want   = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_backpressure();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
